// File: rtl/m_ucodeseq_if.sv
// Sequencer-side bundle: current ROM word fields, condition/dispatch inputs, bus/irq handshakes, ROM address out.
interface m_ucodeseq_if;
  logic [7:0] d_nxt;
  logic [2:0] d_ctl;
  logic       cond;
  logic [5:0] disp;
  logic       ack;
  logic       irq;
  logic       restart;
  logic [7:0] minx;
  logic       progress_ucode;
  logic       halted;
  logic       stall_to;

  modport master (
    output d_nxt, d_ctl, cond, disp, ack, irq, restart,
    input  minx, progress_ucode, halted, stall_to
  );

  modport slave (
    input  d_nxt, d_ctl, cond, disp, ack, irq, restart,
    output minx, progress_ucode, halted, stall_to
  );
endinterface

// File: rtl/m_ucodeseq.sv
// Microcode sequencer feeding the registered control ROM: next-address select, boot, halt, bus timeout.
// Optional 2-entry return stack for CALL/RET when UCODE_CALLSTACK_EN is defined.
module m_ucodeseq #(
  parameter logic [7:0]  RESET_ADDR = 8'h00,
  parameter logic [7:0]  TRAP_ADDR  = 8'hF0,
  parameter logic [7:0]  IRQ_ADDR   = 8'hF8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  m_ucodeseq_if.slave  bus
);

  localparam int unsigned AW        = 8;
  localparam logic [7:0]  WCNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;
  typedef enum logic [2:0] {
    OP_NEXT, OP_BRCOND, OP_DISPATCH, OP_WAITACK, OP_TRAP, OP_CALL, OP_RET, OP_HALT
  } op_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic          halted_q, halted_d;
  logic          stall_to_q, stall_to_d;
  logic [AW-1:0] minx_c;
  logic          pe_c;
  op_e           op;

`ifdef UCODE_CALLSTACK_EN
  logic [AW-1:0] stk0_q, stk0_d, stk1_q, stk1_d;
  logic [1:0]    sp_q, sp_d;
  logic [AW-1:0] ret_addr;
  assign ret_addr = AW'(cur_q + 8'd1);
`endif

  assign op = op_e'(bus.d_ctl);

  // Next-address select; cur follows every address the ROM accepts
  always_comb begin
    state_d    = state_q;
    wcnt_d     = 8'd0;
    halted_d   = halted_q;
    stall_to_d = 1'b0;
    minx_c     = cur_q;
    pe_c       = 1'b0;
`ifdef UCODE_CALLSTACK_EN
    stk0_d     = stk0_q;
    stk1_d     = stk1_q;
    sp_d       = sp_q;
`endif
    case (state_q)
      ST_BOOT: begin
        minx_c   = RESET_ADDR;
        pe_c     = 1'b1;
        state_d  = ST_RUN;
        halted_d = 1'b0;
      end
      ST_RUN: begin
        pe_c = 1'b1;
        case (op)
          OP_NEXT:     minx_c = bus.d_nxt;
          OP_BRCOND:   minx_c = {bus.d_nxt[7:1], bus.cond};
          OP_DISPATCH: minx_c = bus.irq ? IRQ_ADDR : {2'b00, bus.disp};
          OP_WAITACK: begin
            // ack has priority over an expiring timeout
            if (bus.ack) begin
              minx_c = bus.d_nxt;
            end else if (wcnt_q == WCNT_LAST) begin
              minx_c     = TRAP_ADDR;
              stall_to_d = 1'b1;
            end else begin
              pe_c   = 1'b0;
              minx_c = cur_q;
              wcnt_d = wcnt_q + 8'd1;
            end
          end
          OP_TRAP:     minx_c = TRAP_ADDR;
`ifdef UCODE_CALLSTACK_EN
          OP_CALL: begin
            minx_c = bus.d_nxt;
            // full stack drops its oldest entry
            case (sp_q)
              2'd0:    begin stk0_d = ret_addr; sp_d = 2'd1; end
              2'd1:    begin stk1_d = ret_addr; sp_d = 2'd2; end
              default: begin stk0_d = stk1_q; stk1_d = ret_addr; sp_d = 2'd2; end
            endcase
          end
          OP_RET: begin
            case (sp_q)
              2'd0:    minx_c = TRAP_ADDR;
              2'd1:    begin minx_c = stk0_q; sp_d = 2'd0; end
              default: begin minx_c = stk1_q; sp_d = 2'd1; end
            endcase
          end
`else
          OP_CALL:     minx_c = bus.d_nxt;
          OP_RET:      minx_c = bus.d_nxt;
`endif
          OP_HALT: begin
            pe_c     = 1'b0;
            minx_c   = cur_q;
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
          default:     minx_c = bus.d_nxt;
        endcase
      end
      ST_HALT: begin
        // ROM output is frozen on the HALT word, so its d_nxt is still valid
        if (bus.restart) begin
          minx_c   = bus.d_nxt;
          pe_c     = 1'b1;
          state_d  = ST_RUN;
          halted_d = 1'b0;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    cur_d = pe_c ? minx_c : cur_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      cur_q      <= RESET_ADDR;
      wcnt_q     <= 8'd0;
      halted_q   <= 1'b0;
      stall_to_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      wcnt_q     <= wcnt_d;
      halted_q   <= halted_d;
      stall_to_q <= stall_to_d;
    end
  end

`ifdef UCODE_CALLSTACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk0_q <= '0;
      stk1_q <= '0;
      sp_q   <= 2'd0;
    end else begin
      stk0_q <= stk0_d;
      stk1_q <= stk1_d;
      sp_q   <= sp_d;
    end
  end
`endif

  assign bus.minx           = minx_c;
  assign bus.progress_ucode = pe_c;
  assign bus.halted         = halted_q;
  assign bus.stall_to       = stall_to_q;

endmodule

// File: tb/tb_m_ucodeseq.sv
// Self-checking bench for m_ucodeseq: directed table, multi-cycle corner sequences, random run vs. reference model.
module tb_m_ucodeseq;

  localparam logic [7:0] RST_A   = 8'h00;
  localparam logic [7:0] TRAP_A  = 8'hF0;
  localparam logic [7:0] IRQ_A   = 8'hF8;
  localparam int         TMO     = 16;

  typedef struct packed {
    logic [2:0] ctl;
    logic [7:0] nxt;
    logic       cond;
    logic [5:0] disp;
    logic       ack;
    logic       irq;
    logic       restart;
    logic [7:0] exp_minx;
    logic       exp_pe;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  m_ucodeseq_if u_if ();
  m_ucodeseq dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: mode 0 boot, 1 run, 2 halt
  int         m_mode;
  logic [7:0] m_cur;
  int         m_wait;
  logic       m_halted;
  logic       m_stall;
  logic       m_last_pe;
  logic [7:0] m_stack[$];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cur = RST_A; m_wait = 0; m_halted = 1'b0; m_stall = 1'b0;
    m_last_pe = 1'b1;
    m_stack.delete();
  endtask

  task automatic model_eval(input vec_t v, output logic [7:0] m, output logic pe, output logic to);
    logic [7:0] n;
    n = v.nxt;
    to = 1'b0; pe = 1'b1; m = n;
    if (m_mode == 0) begin
      m = RST_A;
    end else if (m_mode == 2) begin
      if (!v.restart) begin m = m_cur; pe = 1'b0; end
    end else begin
      case (v.ctl)
        3'd1: m = {n[7:1], v.cond};
        3'd2: m = v.irq ? IRQ_A : {2'b00, v.disp};
        3'd3: begin
          if (v.ack) m = n;
          else if (m_wait == TMO - 1) begin m = TRAP_A; to = 1'b1; end
          else begin m = m_cur; pe = 1'b0; end
        end
        3'd4: m = TRAP_A;
`ifdef UCODE_CALLSTACK_EN
        3'd6: m = (m_stack.size() > 0) ? m_stack[$] : TRAP_A;
`endif
        3'd7: begin m = m_cur; pe = 1'b0; end
        default: m = n;
      endcase
    end
  endtask

  task automatic model_update(input vec_t v, input logic [7:0] m, input logic pe, input logic to);
    logic [7:0] old;
    old = m_cur;
    if (m_mode == 0) begin
      m_mode = 1; m_cur = m; m_wait = 0; m_stall = 1'b0; m_halted = 1'b0;
    end else if (m_mode == 2) begin
      m_stall = 1'b0;
      if (v.restart) begin m_mode = 1; m_halted = 1'b0; m_cur = m; end
    end else begin
      m_stall = to;
      if (pe) m_cur = m;
      m_wait = (v.ctl == 3'd3 && !v.ack && !to) ? m_wait + 1 : 0;
      if (v.ctl == 3'd7) begin m_mode = 2; m_halted = 1'b1; end
`ifdef UCODE_CALLSTACK_EN
      if (v.ctl == 3'd5) begin
        m_stack.push_back(8'(old + 8'd1));
        if (m_stack.size() > 2) void'(m_stack.pop_front());
      end
      if (v.ctl == 3'd6 && m_stack.size() > 0) void'(m_stack.pop_back());
`endif
    end
    m_last_pe = pe;
  endtask

  // One cycle: drive at negedge, check outputs against the model, advance model at posedge
  task automatic step(input vec_t v, output logic [7:0] am, output logic ape);
    logic [7:0] em;
    logic       epe, eto;
    @(negedge clk);
    u_if.d_ctl = v.ctl; u_if.d_nxt = v.nxt; u_if.cond = v.cond; u_if.disp = v.disp;
    u_if.ack = v.ack; u_if.irq = v.irq; u_if.restart = v.restart;
    #1;
    model_eval(v, em, epe, eto);
    am = u_if.minx; ape = u_if.progress_ucode;
    check("minx", {1'b0, am}, {1'b0, em});
    check("progress_ucode", {8'd0, ape}, {8'd0, epe});
    check("halted", {8'd0, u_if.halted}, {8'd0, m_halted});
    check("stall_to", {8'd0, u_if.stall_to}, {8'd0, m_stall});
    @(posedge clk);
    model_update(v, em, epe, eto);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_minx", {1'b0, u_if.minx}, {1'b0, RST_A});
    check("rst_pe", {8'd0, u_if.progress_ucode}, 9'd1);
    check("rst_halted", {8'd0, u_if.halted}, 9'd0);
    check("rst_stall_to", {8'd0, u_if.stall_to}, 9'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [2:0] ctl, input logic [7:0] nxt, input logic cond,
                              input logic [5:0] disp, input logic ack, input logic irq,
                              input logic rs, input logic [7:0] em, input logic epe);
    vec_t v;
    v.ctl = ctl; v.nxt = nxt; v.cond = cond; v.disp = disp; v.ack = ack; v.irq = irq;
    v.restart = rs; v.exp_minx = em; v.exp_pe = epe;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl[$];
    vec_t       v;
    logic [7:0] am;
    logic       ape;
    int         stalls;

    u_if.d_ctl = '0; u_if.d_nxt = '0; u_if.cond = 1'b0; u_if.disp = '0;
    u_if.ack = 1'b0; u_if.irq = 1'b0; u_if.restart = 1'b0;
    do_reset();

    // boot cycle ignores d, then the main opcodes with expected results from first principles
    tbl.push_back(mk(3'd7, 8'hAA, 0, 6'h00, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mk(3'd0, 8'h10, 0, 6'h00, 0, 0, 0, 8'h10, 1));
    tbl.push_back(mk(3'd1, 8'h40, 1, 6'h00, 0, 0, 0, 8'h41, 1));
    tbl.push_back(mk(3'd1, 8'h40, 0, 6'h00, 0, 0, 0, 8'h40, 1));
    tbl.push_back(mk(3'd2, 8'h00, 0, 6'h15, 0, 0, 0, 8'h15, 1));
    tbl.push_back(mk(3'd2, 8'h00, 0, 6'h15, 0, 1, 0, 8'hF8, 1));
    tbl.push_back(mk(3'd4, 8'h33, 0, 6'h00, 0, 0, 0, 8'hF0, 1));
    tbl.push_back(mk(3'd3, 8'h22, 0, 6'h00, 0, 0, 0, 8'hF0, 0));
    tbl.push_back(mk(3'd3, 8'h22, 0, 6'h00, 0, 0, 0, 8'hF0, 0));
    tbl.push_back(mk(3'd3, 8'h22, 0, 6'h00, 0, 0, 0, 8'hF0, 0));
    tbl.push_back(mk(3'd3, 8'h22, 0, 6'h00, 1, 0, 0, 8'h22, 1));
    tbl.push_back(mk(3'd0, 8'hFF, 0, 6'h00, 0, 0, 0, 8'hFF, 1));
    tbl.push_back(mk(3'd2, 8'h00, 0, 6'h3F, 0, 0, 0, 8'h3F, 1));
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], am, ape);
      check($sformatf("tbl%0d_minx", i), {1'b0, am}, {1'b0, tbl[i].exp_minx});
      check($sformatf("tbl%0d_pe", i), {8'd0, ape}, {8'd0, tbl[i].exp_pe});
    end

    // bus timeout: 15 stalled cycles, trap on the 16th, one-cycle stall_to pulse
    stalls = 0;
    for (int i = 0; i < TMO; i++) begin
      step(mk(3'd3, 8'h55, 0, 0, 0, 0, 0, 0, 0), am, ape);
      if (!ape) stalls++;
    end
    check("to_stalls", 9'(stalls), 9'(TMO - 1));
    check("to_minx", {1'b0, am}, {1'b0, TRAP_A});
    step(mk(3'd0, 8'h01, 0, 0, 0, 0, 0, 0, 0), am, ape);
    check("to_pulse", {8'd0, u_if.stall_to}, 9'd1);
    step(mk(3'd0, 8'h02, 0, 0, 0, 0, 0, 0, 0), am, ape);
    check("to_pulse_end", {8'd0, u_if.stall_to}, 9'd0);

    // halt for 10 cycles, irq ignored, then restart
    step(mk(3'd7, 8'h66, 0, 0, 0, 0, 0, 0, 0), am, ape);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      step(mk(3'd7, 8'h66, 0, 0, 0, 1, 0, 0, 0), am, ape);
      if (!ape && u_if.halted) stalls++;
    end
    check("halt_cycles", 9'(stalls), 9'd10);
    step(mk(3'd7, 8'h66, 0, 0, 0, 0, 1, 0, 0), am, ape);
    check("restart_minx", {1'b0, am}, 9'h066);
    check("restart_pe", {8'd0, ape}, 9'd1);
    step(mk(3'd0, 8'h07, 0, 0, 0, 0, 0, 0, 0), am, ape);
    check("restart_halted", {8'd0, u_if.halted}, 9'd0);

    // call depth beyond the stack: third RET traps when the stack exists
    step(mk(3'd5, 8'hA0, 0, 0, 0, 0, 0, 0, 0), am, ape);
    step(mk(3'd5, 8'hB0, 0, 0, 0, 0, 0, 0, 0), am, ape);
    step(mk(3'd5, 8'hC0, 0, 0, 0, 0, 0, 0, 0), am, ape);
    step(mk(3'd6, 8'hD0, 0, 0, 0, 0, 0, 0, 0), am, ape);
    step(mk(3'd6, 8'hD1, 0, 0, 0, 0, 0, 0, 0), am, ape);
    step(mk(3'd6, 8'hD2, 0, 0, 0, 0, 0, 0, 0), am, ape);
`ifdef UCODE_CALLSTACK_EN
    check("ret3_minx", {1'b0, am}, {1'b0, TRAP_A});
`else
    check("ret3_minx", {1'b0, am}, 9'h0D2);
`endif

    // reset in the middle of a bus wait, stack left with an entry
    step(mk(3'd5, 8'h80, 0, 0, 0, 0, 0, 0, 0), am, ape);
    step(mk(3'd3, 8'h90, 0, 0, 0, 0, 0, 0, 0), am, ape);
    step(mk(3'd3, 8'h90, 0, 0, 0, 0, 0, 0, 0), am, ape);
    do_reset();
    step(mk(3'd3, 8'h90, 0, 0, 1, 0, 0, 0, 0), am, ape);
    check("reboot_minx", {1'b0, am}, {1'b0, RST_A});
    step(mk(3'd6, 8'h91, 0, 0, 0, 0, 0, 0, 0), am, ape);

    // random run; ROM word stays frozen whenever the last address was not accepted
    v = mk(3'd0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      int r;
      if (m_last_pe) begin
        r = int'($urandom_range(0, 15));
        if (r == 0) v.ctl = 3'd7;
        else if (r < 5) v.ctl = 3'd3;
        else v.ctl = 3'(r % 7);
        v.nxt = 8'($urandom);
      end
      v.cond = 1'($urandom);
      v.disp = 6'($urandom);
      v.ack = ($urandom_range(0, 7) == 0);
      v.irq = 1'($urandom);
      v.restart = ($urandom_range(0, 3) == 0);
      step(v, am, ape);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
